// File: rtl/csa_accum_ctrl.sv
// rtl/csa_accum_ctrl.sv - serial carry-save accumulator summing NUM_OPS streamed operands
module csa_accum_ctrl #(
    parameter int WIDTH   = 16,
    parameter int NUM_OPS = 9,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int ACC_W = WIDTH + CNT_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OPS - 1);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;

    logic [ACC_W-1:0] x_ext;
    logic [ACC_W-1:0] maj;
    logic [ACC_W-1:0] total;

    // carry_q is kept already shifted, so the CSA row adds three aligned vectors
    assign x_ext = {{CNT_W{1'b0}}, in_data};
    assign maj   = (sum_q & carry_q) | (sum_q & x_ext) | (carry_q & x_ext);
    assign total = sum_q + carry_q;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    sum_d   = sum_q ^ carry_q ^ x_ext;
                    carry_d = {maj[ACC_W-2:0], 1'b0};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                s_d     = total[WIDTH-1:0];
                cout_d  = |total[ACC_W-1:WIDTH];
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready = (state_q == ST_ACCUM);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign op_count = cnt_q;
    assign S        = s_q;
    assign Cout     = cout_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb/tb_csa_accum_ctrl.sv - randomized self-checking bench for csa_accum_ctrl
module tb_csa_accum_ctrl;

    localparam int W = 16;
    localparam int N = 9;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         busy;
    logic [C-1:0] op_count;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;

    csa_accum_ctrl #(.WIDTH(W), .NUM_OPS(N), .CNT_W(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .op_count (op_count),
        .done     (done),
        .S        (S),
        .Cout     (Cout)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] ops [N];
    logic [W-1:0] prev_s;
    logic         prev_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: plain integer sum of the operands of one run
    function automatic longint ref_total();
        longint t = 0;
        for (int k = 0; k < N; k++) t += longint'(ops[k]);
        return t;
    endfunction

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_ready", 32'(in_ready), 32'd1);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_count0", 32'(op_count), 32'd0);
        chk("run_s_held", 32'(S), 32'(prev_s));
    endtask

    task automatic feed(input bit gaps, input int count, input bit poke_start);
        for (int k = 0; k < count; k++) begin
            if (gaps) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                    in_valid = 1'b0;
                    in_data  = W'($urandom);
                    start    = poke_start;
                    tick();
                    start = 1'b0;
                    chk("bubble_hold", 32'(op_count), 32'(k));
                end
            end
            in_valid = 1'b1;
            in_data  = ops[k];
            start    = poke_start && (k == 2);
            chk("accept_ready", 32'(in_ready), 32'd1);
            tick();
            start    = 1'b0;
            in_valid = 1'b0;
            chk("accept_count", 32'(op_count), 32'(k + 1));
        end
    endtask

    task automatic finish_run(input bit poke);
        longint       t;
        logic [W-1:0] es;
        logic         ec;
        t  = ref_total();
        es = W'(t % 65536);
        ec = (t >= 65536);
        if (poke) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
        end
        chk("resolve_ready", 32'(in_ready), 32'd0);
        chk("resolve_done", 32'(done), 32'd0);
        chk("resolve_s_held", 32'(S), 32'(prev_s));
        tick();
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_s", 32'(S), 32'(es));
        chk("done_cout", 32'(Cout), 32'(ec));
        chk("done_count", 32'(op_count), 32'(N));
        chk("done_ready", 32'(in_ready), 32'd0);
        start = poke;
        tick();
        start = 1'b0;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_count", 32'(op_count), 32'(N));
        chk("idle_s_hold", 32'(S), 32'(es));
        if (poke) begin
            chk("idle_ready", 32'(in_ready), 32'd0);
            tick();
            chk("no_queued_start", 32'(busy), 32'd0);
            chk("idle_no_accept", 32'(op_count), 32'(N));
            in_valid = 1'b0;
        end
        prev_s = es;
        prev_c = ec;
    endtask

    initial begin
        logic [W-1:0] t1 [N];
        t1 = '{16'd2, 16'd3, 16'd5, 16'd9, 16'd13, 16'd18, 16'd21, 16'd32, 16'd15};
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        prev_s   = '0;
        prev_c   = 1'b0;
        #12;
        chk("rst_s", 32'(S), 32'd0);
        chk("rst_cout", 32'(Cout), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // basic run, back-to-back
        ops = t1;
        begin_run();
        feed(1'b0, N, 1'b0);
        finish_run(1'b0);
        chk("t1_s_118", 32'(S), 32'd118);

        // all-ones overflow
        for (int k = 0; k < N; k++) ops[k] = 16'hFFFF;
        begin_run();
        feed(1'b0, N, 1'b0);
        finish_run(1'b0);
        chk("t2_s", 32'(S), 32'h0000FFF7);
        chk("t2_cout", 32'(Cout), 32'd1);

        // bubbles between operands
        ops = t1;
        begin_run();
        feed(1'b1, N, 1'b0);
        finish_run(1'b0);

        // stray start and in_valid outside ACCUM
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        chk("idle_valid_ignored", 32'(op_count), 32'(N));
        chk("idle_valid_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        begin_run();
        feed(1'b1, N, 1'b1);
        finish_run(1'b1);
        chk("t4_s_118", 32'(S), 32'd118);

        // asynchronous reset mid-run
        for (int k = 0; k < N; k++) ops[k] = 16'd1;
        begin_run();
        feed(1'b0, 4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_s", 32'(S), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_count", 32'(op_count), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        prev_s = '0;
        prev_c = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_stay_idle", 32'(busy), 32'd0);
        begin_run();
        feed(1'b0, N, 1'b0);
        finish_run(1'b0);
        chk("t5_s_9", 32'(S), 32'd9);

        // two consecutive runs, start right after done
        for (int k = 0; k < N; k++) ops[k] = '0;
        begin_run();
        feed(1'b0, N, 1'b0);
        finish_run(1'b0);
        for (int k = 0; k < N; k++) ops[k] = W'(k + 1);
        begin_run();
        feed(1'b0, N, 1'b0);
        finish_run(1'b0);
        chk("t6_s_45", 32'(S), 32'd45);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < N; k++) begin
                ops[k] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom);
            end
            begin_run();
            feed(bit'($urandom_range(0, 1)), N, bit'($urandom_range(0, 1)));
            finish_run(bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
